// File: rtl/tim_pkg.sv
// tim_pkg: opcodes, ALU function codes, jump conditions and the default reset vector.
package tim_pkg;
    localparam logic [22:0] RESET_VECTOR_DEF = 23'h40E000;
    typedef enum logic [3:0] {
        OP_ALU  = 4'd0,
        OP_ADDI = 4'd1,
        OP_LD   = 4'd2,
        OP_ST   = 4'd3,
        OP_LUI  = 4'd4,
        OP_JMP  = 4'd5,
        OP_HALT = 4'd15
    } opcode_e;
    typedef enum logic [2:0] {
        FN_ADD = 3'd0,
        FN_SUB = 3'd1,
        FN_AND = 3'd2,
        FN_OR  = 3'd3,
        FN_XOR = 3'd4,
        FN_SHL = 3'd5,
        FN_SHR = 3'd6,
        FN_SLT = 3'd7
    } alu_fn_e;
    typedef enum logic [2:0] {
        CC_NEVER  = 3'd0,
        CC_Z      = 3'd1,
        CC_NZ     = 3'd2,
        CC_N      = 3'd3,
        CC_ALWAYS = 3'd4
    } cond_e;
endpackage

// File: rtl/tim_devices.sv
// devices: 2^23 x 16 word memory with fetch and data read ports and one clocked write port.
module devices (
    input  logic        clk_i,
    input  logic [22:0] iaddr_i,
    output logic [15:0] idata_o,
    input  logic [22:0] daddr_i,
    output logic [15:0] ddata_o,
    input  logic        we_i,
    input  logic [15:0] wdata_i
);
    logic [15:0] mem [0:(1<<23)-1];
    assign idata_o = mem[iaddr_i];
    assign ddata_o = mem[daddr_i];
    always_ff @(posedge clk_i) begin
        if (we_i) mem[daddr_i] <= wdata_i;
    end
endmodule

// File: rtl/tim.sv
// tim: single-cycle 16-bit computer; CPU decode and datapath around the DEVICES memory.
module tim import tim_pkg::*; #(
    parameter logic [22:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input logic _CLK,
    input logic RESET
);
    logic [22:0] pc_q = RESET_VECTOR;
    logic [22:0] pc_d;
    logic [15:0] regs_q [8] = '{default: '0};
    logic        z_q = 1'b0;
    logic        n_q = 1'b0;
    logic        z_d, n_d, wb_en, we, taken;
    logic [15:0] instr, rdata, rs_v, rt_v, rd_v, simm, ea, alu_y, wb_v;
    opcode_e     op;
    alu_fn_e     fn;
    cond_e       cond;
    assign op   = opcode_e'(instr[15:12]);
    assign fn   = alu_fn_e'(instr[2:0]);
    assign cond = cond_e'(instr[11:9]);
    assign simm = {{10{instr[5]}}, instr[5:0]};
    assign rs_v = regs_q[instr[8:6]];
    assign rt_v = regs_q[instr[5:3]];
    assign rd_v = regs_q[instr[11:9]];
    assign ea   = rs_v + simm;
    devices DEVICES (
        .clk_i   (_CLK),
        .iaddr_i (pc_q),
        .idata_o (instr),
        .daddr_i ({7'b0, ea}),
        .ddata_o (rdata),
        .we_i    (we & ~RESET),
        .wdata_i (rd_v)
    );
    always_comb begin
        case (fn)
            FN_ADD:  alu_y = rs_v + rt_v;
            FN_SUB:  alu_y = rs_v - rt_v;
            FN_AND:  alu_y = rs_v & rt_v;
            FN_OR:   alu_y = rs_v | rt_v;
            FN_XOR:  alu_y = rs_v ^ rt_v;
            FN_SHL:  alu_y = {rs_v[14:0], 1'b0};
            FN_SHR:  alu_y = {1'b0, rs_v[15:1]};
            default: alu_y = {15'b0, $signed(rs_v) < $signed(rt_v)};
        endcase
    end
    always_comb begin
        case (cond)
            CC_Z:      taken = z_q;
            CC_NZ:     taken = ~z_q;
            CC_N:      taken = n_q;
            CC_ALWAYS: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end
    always_comb begin
        pc_d  = pc_q + 23'd1;
        z_d   = z_q;
        n_d   = n_q;
        wb_en = 1'b0;
        wb_v  = alu_y;
        we    = 1'b0;
        case (op)
            OP_ALU, OP_ADDI: begin
                wb_en = 1'b1;
                wb_v  = (op == OP_ALU) ? alu_y : ea;
                z_d   = (wb_v == 16'd0);
                n_d   = wb_v[15];
            end
            OP_LD: begin
                wb_en = 1'b1;
                wb_v  = rdata;
            end
            OP_ST:   we = 1'b1;
            OP_LUI: begin
                wb_en = 1'b1;
                wb_v  = {instr[8:0], 7'b0};
            end
            OP_JMP:  pc_d = taken ? {7'b0, ea} : pc_q + 23'd1;
            OP_HALT: pc_d = pc_q;
            default: ;
        endcase
    end
    // $0 is never written, so its zero reset value makes it read as 0.
    always_ff @(posedge _CLK) begin
        if (RESET) begin
            pc_q   <= RESET_VECTOR;
            regs_q <= '{default: '0};
            z_q    <= 1'b0;
            n_q    <= 1'b0;
        end else begin
            pc_q <= pc_d;
            z_q  <= z_d;
            n_q  <= n_d;
            if (wb_en && instr[11:9] != 3'd0) regs_q[instr[11:9]] <= wb_v;
        end
    end
endmodule

// File: tb/tb_tim.sv
// tb_tim: directed program run on tim with hand-computed expected state after each step.
module tb_tim;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total = 0;

    tim TIM (._CLK(clk), .RESET(rst));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        TIM.DEVICES.mem[23'h40E000] = 16'h5800;
        TIM.DEVICES.mem[0]  = 16'h1205;
        TIM.DEVICES.mem[1]  = 16'h143D;
        TIM.DEVICES.mem[2]  = 16'h0650;
        TIM.DEVICES.mem[3]  = 16'h360A;
        TIM.DEVICES.mem[4]  = 16'h280A;
        TIM.DEVICES.mem[5]  = 16'h0A49;
        TIM.DEVICES.mem[6]  = 16'h52DE;
        TIM.DEVICES.mem[10] = 16'h0000;
        TIM.DEVICES.mem[32] = 16'h5400;
        TIM.DEVICES.mem[33] = 16'h1007;
        TIM.DEVICES.mem[34] = 16'h1C1F;
        TIM.DEVICES.mem[35] = 16'h0E8F;
        TIM.DEVICES.mem[36] = 16'h4BFF;
        TIM.DEVICES.mem[37] = 16'h6FFF;
        TIM.DEVICES.mem[38] = 16'h5991;
        TIM.DEVICES.mem[48] = 16'hF000;
        #1;
        chk("pc_time0", 32'(TIM.pc_q), 32'h40E000);
        step();
        chk("pc_reset", 32'(TIM.pc_q), 32'h40E000);
        chk("r1_reset", 32'(TIM.regs_q[1]), 32'h0);
        chk("z_reset", 32'(TIM.z_q), 32'h0);
        rst = 1'b0;
        step();
        chk("pc_jmp0", 32'(TIM.pc_q), 32'h0);
        step();
        chk("r1_addi", 32'(TIM.regs_q[1]), 32'h5);
        step();
        chk("r2_addi_neg", 32'(TIM.regs_q[2]), 32'hFFFD);
        chk("n_neg", 32'(TIM.n_q), 32'h1);
        step();
        chk("r3_add", 32'(TIM.regs_q[3]), 32'h2);
        chk("z_add", 32'(TIM.z_q), 32'h0);
        chk("n_add", 32'(TIM.n_q), 32'h0);
        step();
        chk("mem10_st", 32'(TIM.DEVICES.mem[10]), 32'h2);
        step();
        chk("r4_ld", 32'(TIM.regs_q[4]), 32'h2);
        step();
        chk("r5_sub", 32'(TIM.regs_q[5]), 32'h0);
        chk("z_sub", 32'(TIM.z_q), 32'h1);
        step();
        chk("pc_jz_taken", 32'(TIM.pc_q), 32'h20);
        step();
        chk("pc_jnz_not", 32'(TIM.pc_q), 32'h21);
        step();
        chk("r0_zero", 32'(TIM.regs_q[0]), 32'h0);
        chk("pc_after_r0", 32'(TIM.pc_q), 32'h22);
        step();
        chk("r6_addi", 32'(TIM.regs_q[6]), 32'h1F);
        step();
        chk("r7_slt", 32'(TIM.regs_q[7]), 32'h1);
        step();
        chk("r5_lui", 32'(TIM.regs_q[5]), 32'hFF80);
        chk("z_lui_kept", 32'(TIM.z_q), 32'h0);
        step();
        chk("pc_nop", 32'(TIM.pc_q), 32'h26);
        step();
        chk("pc_jmp_always", 32'(TIM.pc_q), 32'h30);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pc_halt", 32'(TIM.pc_q), 32'h30);
        end
        rst = 1'b1;
        step();
        chk("pc_midreset", 32'(TIM.pc_q), 32'h40E000);
        chk("r3_midreset", 32'(TIM.regs_q[3]), 32'h0);
        chk("r7_midreset", 32'(TIM.regs_q[7]), 32'h0);
        chk("mem10_kept", 32'(TIM.DEVICES.mem[10]), 32'h2);
        rst = 1'b0;
        TIM.DEVICES.mem[10] = 16'hBEEF;
        for (int i = 0; i < 4; i++) step();
        chk("pc_before_abort", 32'(TIM.pc_q), 32'h3);
        chk("r3_rerun", 32'(TIM.regs_q[3]), 32'h2);
        rst = 1'b1;
        step();
        chk("mem10_abort", 32'(TIM.DEVICES.mem[10]), 32'hBEEF);
        chk("r3_abort", 32'(TIM.regs_q[3]), 32'h0);
        chk("pc_abort", 32'(TIM.pc_q), 32'h40E000);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
